uart_rx_ctrl_fsm: RTL and testbench
===================================

Name: uart_rx_ctrl_fsm

Overview:
Sequencing controller for the UART receiver. It owns the per-bit edge counter and the per-frame bit counter. It drives the data-sampling enable and the edge count into the 3-sample majority sampler, and the strobes for the deserializer and the start/parity/stop checkers. It issues a one-cycle data_valid pulse when a frame completes without error.

Parameters:
DATA_WIDTH, 8, data bits per frame (LSB first); bit_cnt width = 4
EDGE_W, 4, edge counter width; supports Prescale 8 and 16

Ports:
CLK_FSM  input  1  receiver oversampling clock
RST_FSM  input  1  reset, synchronous, active-high
RX_IN_FSM  input  1  serial line, already synchronised, idle = 1
PAR_EN_FSM  input  1  parity bit present in frame
Prescale_FSM  input  5  oversampling ratio; 8 or 16, any other value treated as 16
strt_glitch_FSM  input  1  start checker result, valid in the cycle strt_chk_en is high
par_err_FSM  input  1  parity checker result, valid in the cycle par_chk_en is high
stop_err_FSM  input  1  stop checker result, valid in the cycle stop_chk_en is high
edge_cnt_FSM  output  4  edge index within the current bit, 0..Prescale-1
bit_cnt_FSM  output  4  bit index within the frame (0 = start)
dat_samp_en_FSM  output  1  sampler enable
deser_en_FSM  output  1  one-cycle strobe: shift sampled bit into the deserializer
strt_chk_en_FSM  output  1  one-cycle strobe: check start bit
par_chk_en_FSM  output  1  one-cycle strobe: check parity bit
stop_chk_en_FSM  output  1  one-cycle strobe: check stop bit
data_valid_FSM  output  1  one-cycle pulse: frame received clean

Behaviour:
- Reset (RST_FSM=1 at a posedge): state=IDLE; edge_cnt=0; bit_cnt=0; error latches cleared; all outputs 0. A reset mid-frame aborts the frame and produces no data_valid.
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Counters:
  - In every state except IDLE and DONE, edge_cnt increments each cycle.
  - Define last = Prescale-1. At edge_cnt==last ("bit wrap"), edge_cnt goes to 0 and bit_cnt increments.
  - In IDLE both counters are held at 0.
- dat_samp_en = 1 in START, DATA, PARITY and STOP; 0 in IDLE and DONE.
- Check and shift strobes fire only at bit wrap, after the sampler has used edges center±1 (center = 4 for Prescale 8, else 8). At that point sampled_bit is stable. Strobes are combinational on state and edge_cnt.
- Error inputs are sampled in the same cycle as their strobe.
- IDLE:
  - RX_IN==0 -> START, with edge_cnt=0 and bit_cnt=0 loaded.
  - PAR_EN is latched into par_en_q on this transition; mid-frame changes to PAR_EN are ignored.
- START: strt_chk_en at bit wrap.
  - strt_glitch=1 -> IDLE, counters cleared.
  - strt_glitch=0 -> DATA.
- DATA:
  - deser_en at each bit wrap.
  - After the DATA_WIDTH-th wrap (bit_cnt==DATA_WIDTH at the wrap): go to PARITY if par_en_q, else STOP.
- PARITY: par_chk_en at bit wrap. par_err is ORed into err_q. Then -> STOP.
- STOP: stop_chk_en at bit wrap. stop_err is ORed into err_q. Then -> DONE.
- DONE: exactly one cycle.
  - data_valid = !err_q. err_q is cleared.
  - RX_IN==0 -> START with edge_cnt=1, bit_cnt=0. This compensates for the consumed cycle and supports back-to-back frames.
  - Otherwise -> IDLE.
- Frame latency: start falling edge to data_valid = Prescale*(10 + par_en_q) + 1 cycles (IDLE detect cycle included).
- Prescale changes mid-frame are undefined. The bench holds Prescale constant per frame.

Optional Feature:
- Macro: UART_RX_ERR_OUT_EN.
- Defined: adds outputs par_err_out_FSM and stop_err_out_FSM (1 bit each). Each pulses for one cycle in DONE, reflecting its own latched error. Reset value 0.
- Undefined: those ports do not exist; errors only suppress data_valid.

Decomposition:
- Package uart_rx_pkg:
  - state enum (3-bit)
  - DATA_WIDTH
  - PRESCALE_8 and PRESCALE_16 constants
  - center-edge function
- Sub-module uart_rx_edge_bit_cnt: edge and bit counters with enable, wrap detect, clear and load-1 inputs; instantiated once.
- The FSM remains in uart_rx_ctrl_fsm.

Test Plan:
- Prescale=16, PAR_EN=0, frame 0xA5 clean -> 8 deser_en strobes 16 cycles apart; data_valid one pulse 161 cycles after start edge.
- Prescale=8, PAR_EN=1, clean frame; par_err=0 at par_chk_en -> data_valid at cycle 89 after start edge.
- strt_glitch=1 at START wrap -> return to IDLE, no deser_en, bit_cnt=0.
- par_err=1 (or stop_err=1) -> no data_valid. With UART_RX_ERR_OUT_EN, the matching err_out pulses in DONE.
- Back-to-back frames with RX_IN=0 in DONE -> START with edge_cnt=1; second data_valid exactly 160 cycles after the first (Prescale 16, no parity).
- RST_FSM asserted mid-DATA -> next cycle IDLE, all outputs 0, no data_valid; the next frame is received cleanly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver control path.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam int DATA_WIDTH = 8;
  localparam int BIT_W      = 4;

  localparam logic [4:0] PRESCALE_8  = 5'd8;
  localparam logic [4:0] PRESCALE_16 = 5'd16;

  // Any ratio other than 8 behaves as 16.
  function automatic logic [3:0] center_edge(input logic [4:0] prescale);
    return (prescale == PRESCALE_8) ? 4'd4 : 4'd8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Edge-within-bit and bit-within-frame counters; clear beats load-1 beats count.
module uart_rx_edge_bit_cnt #(
  parameter int EDGE_W = 4,
  parameter int BIT_W  = 4
) (
  input  logic              CLK_FSM,
  input  logic              RST_FSM,
  input  logic              en,
  input  logic              clr,
  input  logic              ld1,
  input  logic [EDGE_W-1:0] last_edge,
  output logic [EDGE_W-1:0] edge_cnt,
  output logic [BIT_W-1:0]  bit_cnt,
  output logic              wrap
);

  assign wrap = (edge_cnt == last_edge);

  always_ff @(posedge CLK_FSM) begin
    if (RST_FSM || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (ld1) begin
      edge_cnt <= EDGE_W'(1);
      bit_cnt  <= '0;
    end else if (en) begin
      if (wrap) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else begin
        edge_cnt <= edge_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl_fsm.sv
// UART receiver sequencing FSM. Define UART_RX_ERR_OUT_EN to expose
// per-frame parity/stop error pulses alongside data_valid.
module uart_rx_ctrl_fsm #(
  parameter int DATA_WIDTH = uart_rx_pkg::DATA_WIDTH,
  parameter int EDGE_W     = 4
) (
  input  logic              CLK_FSM,
  input  logic              RST_FSM,
  input  logic              RX_IN_FSM,
  input  logic              PAR_EN_FSM,
  input  logic [4:0]        Prescale_FSM,
  input  logic              strt_glitch_FSM,
  input  logic              par_err_FSM,
  input  logic              stop_err_FSM,
  output logic [EDGE_W-1:0] edge_cnt_FSM,
  output logic [3:0]        bit_cnt_FSM,
  output logic              dat_samp_en_FSM,
  output logic              deser_en_FSM,
  output logic              strt_chk_en_FSM,
  output logic              par_chk_en_FSM,
  output logic              stop_chk_en_FSM,
  output logic              data_valid_FSM
`ifdef UART_RX_ERR_OUT_EN
  ,
  output logic              par_err_out_FSM,
  output logic              stop_err_out_FSM
`endif
);
  import uart_rx_pkg::*;

  state_t            state;
  logic              par_en_q;
  logic              par_err_q;
  logic              stop_err_q;
  logic              wrap;
  logic              cnt_en;
  logic              cnt_clr;
  logic              cnt_ld1;
  logic [EDGE_W-1:0] last_edge;

  // Last edge of a bit is twice the center edge minus one (7 or 15).
  assign last_edge = EDGE_W'({center_edge(Prescale_FSM), 1'b0} - 5'd1);

  always_comb begin
    cnt_en  = (state == START) || (state == DATA) ||
              (state == PARITY) || (state == STOP);
    cnt_clr = (state == IDLE) ||
              ((state == START) && wrap && strt_glitch_FSM) ||
              ((state == DONE) && RX_IN_FSM);
    cnt_ld1 = (state == DONE) && !RX_IN_FSM;
  end

  uart_rx_edge_bit_cnt #(
    .EDGE_W (EDGE_W),
    .BIT_W  (BIT_W)
  ) u_cnt (
    .CLK_FSM   (CLK_FSM),
    .RST_FSM   (RST_FSM),
    .en        (cnt_en),
    .clr       (cnt_clr),
    .ld1       (cnt_ld1),
    .last_edge (last_edge),
    .edge_cnt  (edge_cnt_FSM),
    .bit_cnt   (bit_cnt_FSM),
    .wrap      (wrap)
  );

  // Strobes fire on the bit's last edge, once the sampler has its three votes.
  assign dat_samp_en_FSM = cnt_en;
  assign strt_chk_en_FSM = (state == START)  && wrap;
  assign deser_en_FSM    = (state == DATA)   && wrap;
  assign par_chk_en_FSM  = (state == PARITY) && wrap;
  assign stop_chk_en_FSM = (state == STOP)   && wrap;
  assign data_valid_FSM  = (state == DONE) && !(par_err_q || stop_err_q);

`ifdef UART_RX_ERR_OUT_EN
  assign par_err_out_FSM  = (state == DONE) && par_err_q;
  assign stop_err_out_FSM = (state == DONE) && stop_err_q;
`endif

  always_ff @(posedge CLK_FSM) begin
    if (RST_FSM) begin
      state      <= IDLE;
      par_en_q   <= 1'b0;
      par_err_q  <= 1'b0;
      stop_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!RX_IN_FSM) begin
            state    <= START;
            par_en_q <= PAR_EN_FSM;
          end
        end
        START: begin
          if (wrap) state <= strt_glitch_FSM ? IDLE : DATA;
        end
        DATA: begin
          if (wrap && (bit_cnt_FSM == BIT_W'(DATA_WIDTH)))
            state <= par_en_q ? PARITY : STOP;
        end
        PARITY: begin
          if (wrap) begin
            par_err_q <= par_err_q | par_err_FSM;
            state     <= STOP;
          end
        end
        STOP: begin
          if (wrap) begin
            stop_err_q <= stop_err_q | stop_err_FSM;
            state      <= DONE;
          end
        end
        DONE: begin
          par_err_q  <= 1'b0;
          stop_err_q <= 1'b0;
          // A low line here is already the next start bit's first edge.
          if (!RX_IN_FSM) begin
            state    <= START;
            par_en_q <= PAR_EN_FSM;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl_fsm.sv
// Bench for uart_rx_ctrl_fsm: frame table, hand sequences, and randomized run
// against a frame-offset reference model.
module tb_uart_rx_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       par_en;
  logic [4:0] presc;
  logic       glitch;
  logic       perr;
  logic       serr;
  logic [3:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       samp_en;
  logic       deser_en;
  logic       strt_en;
  logic       par_en_chk;
  logic       stop_en;
  logic       data_valid;
`ifdef UART_RX_ERR_OUT_EN
  logic       par_err_out;
  logic       stop_err_out;
`endif

  int vectors    = 0;
  int miscompares = 0;
  bit chk_on     = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl_fsm dut (
    .CLK_FSM         (clk),
    .RST_FSM         (rst),
    .RX_IN_FSM       (rx),
    .PAR_EN_FSM      (par_en),
    .Prescale_FSM    (presc),
    .strt_glitch_FSM (glitch),
    .par_err_FSM     (perr),
    .stop_err_FSM    (serr),
    .edge_cnt_FSM    (edge_cnt),
    .bit_cnt_FSM     (bit_cnt),
    .dat_samp_en_FSM (samp_en),
    .deser_en_FSM    (deser_en),
    .strt_chk_en_FSM (strt_en),
    .par_chk_en_FSM  (par_en_chk),
    .stop_chk_en_FSM (stop_en),
    .data_valid_FSM  (data_valid)
`ifdef UART_RX_ERR_OUT_EN
    ,
    .par_err_out_FSM  (par_err_out),
    .stop_err_out_FSM (stop_err_out)
`endif
  );

  logic [13:0] outs;
  assign outs = {edge_cnt, bit_cnt, samp_en, deser_en, strt_en, par_en_chk, stop_en, data_valid};

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // A frame is tracked by k: k=0 is the idle cycle that sees the line low,
  // k=1..L are the Prescale-long bit slots, k=L+1 is the completion cycle.
  bit m_busy = 1'b0;
  int m_k    = 0;
  int m_P    = 16;
  bit m_pe   = 1'b0;
  bit m_err  = 1'b0;

  function automatic int peff(input logic [4:0] p);
    return (p == 5'd8) ? 8 : 16;
  endfunction

  function automatic int flen(input bit pe, input int p);
    return (10 + int'(pe)) * p;
  endfunction

  function automatic logic [13:0] model_exp();
    int L;
    logic [3:0] e_edge, e_bit;
    logic samp, des, st, pa, sp, dv;
    if (!m_busy) return '0;
    L = flen(m_pe, m_P);
    if (m_k <= L) begin
      e_edge = 4'((m_k - 1) % m_P);
      e_bit  = 4'((m_k - 1) / m_P);
      samp   = 1'b1;
    end else begin
      e_edge = 4'd0;
      e_bit  = 4'(10 + int'(m_pe));
      samp   = 1'b0;
    end
    st  = (m_k == m_P);
    des = (m_k % m_P == 0) && (m_k >= 2 * m_P) && (m_k <= 9 * m_P);
    pa  = m_pe && (m_k == 10 * m_P);
    sp  = (m_k == L);
    dv  = (m_k == L + 1) && !m_err;
    return {e_edge, e_bit, samp, des, st, pa, sp, dv};
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_k    <= 0;
      m_err  <= 1'b0;
    end else if (!m_busy) begin
      if (!rx) begin
        m_busy <= 1'b1;
        m_k    <= 1;
        m_P    <= peff(presc);
        m_pe   <= par_en;
        m_err  <= 1'b0;
      end
    end else if (m_k == flen(m_pe, m_P) + 1) begin
      m_err <= 1'b0;
      if (!rx) begin
        m_k  <= 2;
        m_P  <= peff(presc);
        m_pe <= par_en;
      end else begin
        m_busy <= 1'b0;
      end
    end else if ((m_k == m_P) && glitch) begin
      m_busy <= 1'b0;
    end else begin
      if (m_pe && (m_k == 10 * m_P) && perr) m_err <= 1'b1;
      if ((m_k == flen(m_pe, m_P)) && serr) m_err <= 1'b1;
      m_k <= m_k + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      vectors++;
      if (outs !== model_exp()) begin
        miscompares++;
        $display("FAIL cycle_model t=%0t: got %h, expected %h", $time, outs, model_exp());
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [4:0] presc;
    bit         pe;
    bit         glitch;
    bit         perr;
    bit         serr;
    int         exp_lat;
    int         exp_deser;
    int         exp_dv;
    int         exp_span;
    int         exp_perr_out;
    int         exp_serr_out;
  } vec_t;

  vec_t tbl[9];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input vec_t v, input int idx);
    int lat, ndes, ndv, first, last, npo, nso;
    lat = 0; ndes = 0; ndv = 0; first = 0; last = 0; npo = 0; nso = 0;
    step();
    presc = v.presc; par_en = v.pe; rx = 1'b1;
    glitch = v.glitch; perr = v.perr; serr = v.serr;
    repeat (2) step();
    rx = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      rx = 1'b1;
      par_en = ~v.pe;
      @(negedge clk);
      if (data_valid) begin ndv++; lat = k; end
      if (deser_en) begin
        if (ndes == 0) first = k;
        last = k;
        ndes++;
      end
`ifdef UART_RX_ERR_OUT_EN
      if (par_err_out) npo++;
      if (stop_err_out) nso++;
`endif
    end
    step();
    par_en = v.pe; glitch = 1'b0; perr = 1'b0; serr = 1'b0;
    check($sformatf("frame%0d_latency", idx), lat, v.exp_lat);
    check($sformatf("frame%0d_deser_count", idx), ndes, v.exp_deser);
    check($sformatf("frame%0d_valid_count", idx), ndv, v.exp_dv);
    check($sformatf("frame%0d_deser_span", idx), last - first, v.exp_span);
`ifdef UART_RX_ERR_OUT_EN
    check($sformatf("frame%0d_par_err_out", idx), npo, v.exp_perr_out);
    check($sformatf("frame%0d_stop_err_out", idx), nso, v.exp_serr_out);
`endif
  endtask

  initial begin
    int dv1, dv2, ndv;
    logic [4:0] pick;

    tbl[0] = '{5'd16, 1'b0, 1'b0, 1'b0, 1'b0, 161, 8, 1, 112, 0, 0};
    tbl[1] = '{5'd8,  1'b1, 1'b0, 1'b0, 1'b0,  89, 8, 1,  56, 0, 0};
    tbl[2] = '{5'd16, 1'b0, 1'b1, 1'b0, 1'b0,   0, 0, 0,   0, 0, 0};
    tbl[3] = '{5'd8,  1'b1, 1'b0, 1'b1, 1'b0,   0, 8, 0,  56, 1, 0};
    tbl[4] = '{5'd16, 1'b1, 1'b0, 1'b0, 1'b1,   0, 8, 0, 112, 0, 1};
    tbl[5] = '{5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 161, 8, 1, 112, 0, 0};
    tbl[6] = '{5'd8,  1'b0, 1'b0, 1'b0, 1'b0,  81, 8, 1,  56, 0, 0};
    tbl[7] = '{5'd16, 1'b1, 1'b0, 1'b0, 1'b0, 177, 8, 1, 112, 0, 0};
    tbl[8] = '{5'd8,  1'b0, 1'b0, 1'b1, 1'b0,  81, 8, 1,  56, 0, 0};

    rst = 1'b1; rx = 1'b1; par_en = 1'b0; presc = 5'd16;
    glitch = 1'b0; perr = 1'b0; serr = 1'b0;
    repeat (2) step();
    chk_on = 1'b1;
    @(negedge clk); #1;
    check("reset_outputs", int'(outs), 0);
    step();
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_frame(tbl[i], i);

    // Back-to-back: line low again in the completion cycle of frame one.
    dv1 = 0; dv2 = 0; ndv = 0;
    presc = 5'd16; par_en = 1'b0;
    repeat (2) step();
    rx = 1'b0;
    for (int k = 1; k <= 340; k++) begin
      step();
      rx = (k == 161) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (data_valid) begin
        ndv++;
        if (ndv == 1) dv1 = k; else dv2 = k;
      end
    end
    check("b2b_valid_count", ndv, 2);
    check("b2b_first_latency", dv1, 161);
    check("b2b_spacing", dv2 - dv1, 160);

    // Reset in the middle of the data bits.
    ndv = 0;
    step();
    rx = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      step();
      rx = 1'b1;
      rst = (k == 50);
      @(negedge clk);
      if (k == 51) begin
        #1;
        check("rst_mid_outputs", int'(outs), 0);
      end
      if (data_valid) ndv++;
    end
    check("rst_mid_no_valid", ndv, 0);
    run_frame(tbl[0], 9);

    // Randomized traffic; the model checks every cycle.
    for (int c = 0; c < 20000; c++) begin
      step();
      rst = ($urandom_range(0, 1999) == 0);
      if (!m_busy) begin
        if ($urandom_range(0, 3) == 0) begin
          case ($urandom_range(0, 7))
            0, 2:    pick = 5'd8;
            1, 3:    pick = 5'd16;
            4:       pick = 5'd5;
            5:       pick = 5'd0;
            6:       pick = 5'd31;
            default: pick = 5'd12;
          endcase
          presc = pick;
        end
        rx = ($urandom_range(0, 3) != 0);
      end else begin
        rx = $urandom_range(0, 1) != 0;
      end
      par_en = $urandom_range(0, 1) != 0;
      glitch = ($urandom_range(0, 7) == 0);
      perr   = ($urandom_range(0, 4) == 0);
      serr   = ($urandom_range(0, 4) == 0);
    end
    step();
    rst = 1'b0; rx = 1'b1; glitch = 1'b0; perr = 1'b0; serr = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
